// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and shared memory port of mem_arbiter
// slave is the arbiter's view; master is the surrounding fetch/data/memory side.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          i_err;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          owner;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_done, i_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_done, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output owner
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_done, i_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_done, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of a fetch port and a data port onto one memory port
// Every output is a register; the comb process computes the next value of each one.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          i_err_q, i_err_d;
    logic          d_err_q, d_err_d;
    logic          grant_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_err_q     <= i_err_d;
            d_err_q     <= d_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_err_d     = 1'b0;
        d_err_d     = 1'b0;
        // On a tie the port that did not hold the last grant wins.
        grant_data  = bus.d_req && (!bus.i_req || !owner_q);

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    owner_d   = grant_data;
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    if (grant_data) begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.i_addr;
                    end
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (bus.mem_ack) begin
                    // A late ack on the final counted cycle still counts as success.
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (owner_q) begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = bus.mem_rdata;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = bus.mem_rdata;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (owner_q) begin
                        d_done_d  = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        i_done_d  = 1'b1;
                        i_err_d   = 1'b1;
                        i_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_err     = d_err_q;
    assign bus.owner     = owner_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter TIMEOUT, default 15, maximum wait in cycles for mem_ack; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 i_req  input  1  fetch-port read request; i_addr held stable while high.
REQ-007 i_addr  input  AW  fetch address.
REQ-008 i_rdata  output  DW  fetch read data, valid when i_done=1.
REQ-009 i_done  output  1  one-cycle completion pulse, fetch port.
REQ-010 i_err  output  1  qualifies i_done: 1 = timed out.
REQ-011 d_req  input  1  data-port request; d_we/d_addr/d_wdata held stable while high.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  AW  data address.
REQ-014 d_wdata  input  DW  store data.
REQ-015 d_rdata  output  DW  load data, valid when d_done=1 and d_we was 0.
REQ-016 d_done  output  1  one-cycle completion pulse, data port.
REQ-017 d_err  output  1  qualifies d_done: 1 = timed out.
REQ-018 mem_req  output  1  request to the shared single-port memory, held until mem_ack or timeout.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  AW  memory address.
REQ-021 mem_wdata  output  DW  memory write data.
REQ-022 mem_rdata  input  DW  memory read data, valid with mem_ack.
REQ-023 mem_ack  input  1  memory completion, one cycle.
REQ-024 owner  output  1  port of current/last grant: 0 = fetch, 1 = data.

Function
REQ-025 FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-026 IDLE: no request -> stay; request(s) present -> latch winner's we/addr/wdata into mem_* registers, set mem_req=1, clear timeout counter, go ACCESS.
REQ-027 Single requester wins; i_req and d_req both high -> grant the port opposite to owner (round-robin).
REQ-028 Fetch grants always drive mem_we=0, mem_wdata unchanged.
REQ-029 ACCESS: mem_* outputs stable; counter increments each cycle without mem_ack.
REQ-030 ACCESS with mem_ack=1 -> mem_req=0; winner's done=1, err=0; for reads, winner's rdata <= mem_rdata; go RESP.
REQ-031 ACCESS with counter reaching TIMEOUT and mem_ack=0 -> mem_req=0; winner's done=1, err=1, rdata <= 0; go RESP.
REQ-032 mem_ack and timeout in same cycle -> mem_ack wins (err=0).
REQ-033 Latency: request seen in IDLE at edge N -> mem_req high after N; mem_ack at edge M -> done high for the cycle after M.
REQ-034 RESP: lasts exactly one cycle; done/err high; requests not sampled; go IDLE. A requester drops req by the edge ending RESP unless issuing a new request.
REQ-035 done and err are 0 outside RESP; both done signals are never high together.
REQ-036 d_rdata unchanged on completed stores; i_rdata/d_rdata otherwise hold last value.
REQ-037 mem_ack in IDLE or RESP ignored.
REQ-038 Back-to-back: continuously held i_req and d_req alternate grants, one transaction per port per round.

Reset
REQ-039 reset=0 forces IDLE immediately, asynchronously; mem_req, mem_we, i_done, d_done, i_err, d_err = 0; mem_addr, mem_wdata, i_rdata, d_rdata, counter = 0; owner = 1 (so first tie grants fetch).
REQ-040 Reset during ACCESS abandons the transaction with no done pulse; a late mem_ack after release is ignored in IDLE.

Verification
REQ-041 i_req only, i_addr=0x100, mem_ack 2 cycles later with mem_rdata=0x00500113 -> mem_req=1, mem_we=0, mem_addr=0x100; i_done=1, i_err=0, i_rdata=0x00500113.
REQ-042 Both requests after reset (d_we=1, d_addr=0x64, d_wdata=0x19) -> fetch granted first (owner=0); then store issued with mem_we=1, mem_addr=0x64, mem_wdata=0x19; d_done pulses, d_rdata unchanged.
REQ-043 d_req load, mem_ack never asserted, TIMEOUT=15 -> mem_req drops after 15 ACCESS cycles; d_done=1, d_err=1, d_rdata=0.
REQ-044 mem_ack on exactly the timeout cycle -> err=0, rdata=mem_rdata.
REQ-045 reset asserted mid-ACCESS -> mem_req=0 immediately, no done pulse; mem_ack after release produces no response.
REQ-046 i_req and d_req held high for 6 transactions -> grants alternate fetch/data/fetch..., exactly one done per transaction, no overlap.
